muldiv_iter_unit: RTL

Parametrised iterative multiply/divide unit for the EX stage of the pipelined RISC-V core. It supports the full RV64M func3 set, where the current core only offers a single-cycle multiply. A start/busy/done handshake lets the EX stage hold the pipeline through a `stall` output. The width is generic, so the same block serves 32- and 64-bit cores.

---
 rtl/muldiv_iter_unit_pkg.sv | 42 ++++
 rtl/muldiv_iter_unit_if.sv | 25 ++
 rtl/muldiv_iter_unit_step.sv | 32 +++
 rtl/muldiv_iter_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_unit_pkg.sv
// Shared definitions for muldiv_iter_unit: RV M func3 codes, FSM states,
// per-operation sign/zero flags and func3 decode helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Captured at accept time so the datapath only ever sees magnitudes.
    typedef struct packed {
        logic a_neg;
        logic b_neg;
        logic a_zero;
        logic b_zero;
        logic ovf;
    } op_flags_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_unit_if.sv
// Request/response bundle between the EX stage (master) and muldiv_iter_unit (slave).
interface muldiv_iter_unit_if #(
    parameter int DATA_W = 64
);
    logic              enable;
    logic              flush;
    logic              start;
    logic [2:0]        func3;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              stall;

    modport master (
        output enable, flush, start, func3, op_a, op_b,
        input  busy, done, result, stall
    );

    modport slave (
        input  enable, flush, start, func3, op_a, op_b,
        output busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_iter_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// {hi,lo} is the product (mul) or {remainder, dividend/quotient} (div); m is multiplicand or divisor.
module muldiv_step #(
    parameter int DATA_W = 64
) (
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] m_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W-1:0] diff;
    logic              fits;

    always_comb begin
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        rem_sh = {hi_i, lo_i[DATA_W-1]};
        fits   = (rem_sh >= {1'b0, m_i});
        // When the subtract fits the difference is below m, so the low bits are exact.
        diff   = rem_sh[DATA_W-1:0] - m_i;
        if (is_div_i) begin
            hi_o = fits ? diff : rem_sh[DATA_W-1:0];
            lo_o = {lo_i[DATA_W-2:0], fits};
        end else begin
            hi_o = sum[DATA_W:1];
            lo_o = {sum[0], lo_i[DATA_W-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M multiply/divide unit: IDLE -> CALC (DATA_W steps) -> FIX -> DONE.
// Optional MULDIV_EARLY_OUT_EN skips CALC for zero operands, divide-by-zero and signed overflow.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              arst,
    muldiv_iter_unit_if.slave bus
);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [DATA_W-1:0] opa_q, opa_d, pend_q, pend_d, result_q, result_d;
    logic [2:0]        f3_q, f3_d;
    op_flags_t         flags_q, flags_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] step_hi, step_lo;
    logic              step_div;
    logic              busy;

    assign step_div = is_div(f3_q);

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div_i (step_div),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Operand preparation for the accepting cycle.
    logic              neg_a, neg_b, in_ovf;
    logic [DATA_W-1:0] abs_a, abs_b;

    always_comb begin
        neg_a  = a_signed(bus.func3) && bus.op_a[DATA_W-1];
        neg_b  = b_signed(bus.func3) && bus.op_b[DATA_W-1];
        abs_a  = neg_a ? -bus.op_a : bus.op_a;
        abs_b  = neg_b ? -bus.op_b : bus.op_b;
        in_ovf = is_div(bus.func3) && b_signed(bus.func3) &&
                 (bus.op_a == MIN_NEG) && (&bus.op_b);
    end

    // Sign correction and result selection, consumed in FIX.
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, fix_val;

    always_comb begin
        prod = {hi_q, lo_q};
        if (flags_q.a_neg ^ flags_q.b_neg) prod = -prod;
        quo = (flags_q.a_neg ^ flags_q.b_neg) ? -lo_q : lo_q;
        rem = flags_q.a_neg ? -hi_q : hi_q;

        if (!is_div(f3_q)) begin
            if (flags_q.a_zero || flags_q.b_zero) fix_val = '0;
            else if (f3_q == F3_MUL)              fix_val = prod[DATA_W-1:0];
            else                                  fix_val = prod[2*DATA_W-1:DATA_W];
        end else if (flags_q.b_zero) begin
            fix_val = f3_q[1] ? opa_q : '1;
        end else if (flags_q.ovf) begin
            fix_val = f3_q[1] ? '0 : opa_q;
        end else begin
            fix_val = f3_q[1] ? rem : quo;
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no branch below can leave a latch behind.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        opa_d    = opa_q;
        pend_d   = pend_q;
        result_d = result_q;
        f3_d     = f3_q;
        flags_d  = flags_q;
        done_d   = done_q;

        if (bus.flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else if (bus.enable) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    // done_q high means this is the pulse cycle; start waits one more cycle.
                    if (bus.start && !done_q) begin
                        f3_d           = bus.func3;
                        opa_d          = bus.op_a;
                        flags_d.a_neg  = neg_a;
                        flags_d.b_neg  = neg_b;
                        flags_d.a_zero = (bus.op_a == '0);
                        flags_d.b_zero = (bus.op_b == '0);
                        flags_d.ovf    = in_ovf;
                        cnt_d          = '0;
                        hi_d           = '0;
                        lo_d           = is_div(bus.func3) ? abs_a : abs_b;
                        m_d            = is_div(bus.func3) ? abs_b : abs_a;
                        state_d        = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        if ((bus.op_a == '0) || (bus.op_b == '0) || in_ovf) state_d = FIX;
`endif
                    end
                end
                CALC: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
                end
                FIX: begin
                    pend_d  = fix_val;
                    state_d = DONE;
                end
                DONE: begin
                    result_d = pend_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments only; the blocking ones live in always_comb.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            opa_q    <= '0;
            pend_q   <= '0;
            result_q <= '0;
            f3_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            opa_q    <= opa_d;
            pend_q   <= pend_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.stall  = busy | (bus.start & ~done_q);

endmodule
